// File: rtl/quad_decoder_counter.sv
// Quadrature decoder with integrated position counter.
// Synchronises and glitch-filters the A/B encoder phases, decodes the Gray
// sequence into up/down steps, accumulates a wrapping position, supports a
// parallel load and raises a sticky flag on illegal double-phase jumps.
module quad_decoder_counter #(
    parameter int WIDTH  = 8,
    parameter int FILTER = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic [WIDTH-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             err
);

    // Filter counter only needs to reach FILTER; it saturates there.
    localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER + 1);

    // Successor of a phase state when the encoder moves in the up direction.
    function automatic logic [1:0] next_up(input logic [1:0] st);
        logic [1:0] r;
        case (st)
            2'b00:   r = 2'b01;
            2'b01:   r = 2'b11;
            2'b11:   r = 2'b10;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       warm_q, warm_d;
    logic [1:0]       cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       filt_q, filt_d;
    logic             filt_vld_q, filt_vld_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;

    logic [1:0]       s;
    logic             hit;
    logic             accept;
    logic             is_up, is_down, is_illegal;

    assign s = sync2_q;

    // Two-flop synchroniser for the asynchronous phase inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {a_in, b_in};
            sync2_q <= sync1_q;
        end
    end

    // Joint 2-bit stability filter. The warm-up phase keeps the reset
    // value of the synchroniser from being mistaken for a real encoder
    // state, so the first accepted value really comes from the pins.
    always_comb begin
        warm_d = warm_q;
        cand_d = cand_q;
        cnt_d  = cnt_q;
        hit    = 1'b0;
        if (warm_q != 2'd2) begin
            warm_d = warm_q + 2'd1;
            cand_d = s;
            cnt_d  = '0;
        end else if (s != cand_q) begin
            cand_d = s;
            cnt_d  = CW'(1);
            hit    = (FILTER == 1);
        end else begin
            if (int'(cnt_q) < FILTER) begin
                cnt_d = cnt_q + CW'(1);
            end
            hit = ((int'(cnt_q) + 1) == FILTER);
        end
    end

    assign accept     = hit && (!filt_vld_q || (s != filt_q));
    assign is_up      = filt_vld_q && (next_up(filt_q) == s);
    assign is_down    = filt_vld_q && (next_up(s) == filt_q);
    assign is_illegal = filt_vld_q && ((filt_q ^ s) == 2'b11);

    // Decode accepted transitions into position, direction, step and error.
    always_comb begin
        filt_d     = filt_q;
        filt_vld_d = filt_vld_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        step_d     = 1'b0;
        err_d      = err_q;

        if (accept) begin
            filt_d     = s;
            filt_vld_d = 1'b1;
        end

        if (clr_err) begin
            err_d = 1'b0;
        end
        if (accept && is_illegal) begin
            err_d = 1'b1;
        end

        // Load wins; the coincident step is dropped but filt still moves on.
        if (load) begin
            pos_d = load_val;
        end else if (accept && is_up) begin
            pos_d  = pos_q + WIDTH'(1);
            dir_d  = 1'b0;
            step_d = 1'b1;
        end else if (accept && is_down) begin
            pos_d  = pos_q - WIDTH'(1);
            dir_d  = 1'b1;
            step_d = 1'b1;
        end
    end

    // Filter and decoder state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_q     <= 2'd0;
            cand_q     <= 2'b00;
            cnt_q      <= '0;
            filt_q     <= 2'b00;
            filt_vld_q <= 1'b0;
            pos_q      <= '0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            warm_q     <= warm_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            filt_vld_q <= filt_vld_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            err_q      <= err_d;
        end
    end

    assign pos  = pos_q;
    assign dir  = dir_q;
    assign step = step_q;
    assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Directed self-checking bench for quad_decoder_counter (WIDTH=8, FILTER=3).
module tb_quad_decoder_counter;

    logic       clk;
    logic       reset;
    logic       a_in;
    logic       b_in;
    logic       load;
    logic [7:0] load_val;
    logic       clr_err;
    logic [7:0] pos;
    logic       dir;
    logic       step;
    logic       err;

    int n_vec;
    int n_err;
    int steps;

    quad_decoder_counter #(.WIDTH(8), .FILTER(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_in     (a_in),
        .b_in     (b_in),
        .load     (load),
        .load_val (load_val),
        .clr_err  (clr_err),
        .pos      (pos),
        .dir      (dir),
        .step     (step),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a phase state, hold for n cycles and count step pulses seen.
    task automatic drive_hold(input logic a, input logic b, input int n, output int cnt);
        a_in = a;
        b_in = b;
        cnt  = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (step) cnt++;
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; a_in = 1'b1; b_in = 1'b1;
        load = 1'b0; load_val = 8'h00; clr_err = 1'b0;

        // Reset values, then priming on 11 produces nothing.
        tick(2);
        chk("rst_pos", 32'(pos), 32'h00);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_step", 32'(step), 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("prime_step", 32'(step), 0);
            chk("prime_err", 32'(err), 0);
        end
        chk("prime_pos", 32'(pos), 32'h00);

        // Re-prime at 00.
        reset = 1'b1; a_in = 1'b0; b_in = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(10);
        chk("prime00_pos", 32'(pos), 32'h00);

        // Forward with wrap: load 0xFE, then 01,11,10,00.
        load = 1'b1; load_val = 8'hFE;
        tick(1);
        load = 1'b0;
        chk("ld_fe", 32'(pos), 32'hFE);
        a_in = 1'b0; b_in = 1'b1;
        tick(4);
        chk("fw_e3_pos", 32'(pos), 32'hFE);
        chk("fw_e3_step", 32'(step), 0);
        tick(1);
        chk("fw_e4_pos", 32'(pos), 32'hFF);
        chk("fw_e4_step", 32'(step), 1);
        chk("fw_e4_dir", 32'(dir), 0);
        tick(1);
        chk("fw_e5_step", 32'(step), 0);
        tick(3);
        drive_hold(1'b1, 1'b1, 6, steps);
        chk("fw_11_pos", 32'(pos), 32'h00);
        chk("fw_11_steps", 32'(steps), 1);
        drive_hold(1'b1, 1'b0, 6, steps);
        chk("fw_10_pos", 32'(pos), 32'h01);
        chk("fw_10_steps", 32'(steps), 1);
        drive_hold(1'b0, 1'b0, 6, steps);
        chk("fw_00_pos", 32'(pos), 32'h02);
        chk("fw_00_steps", 32'(steps), 1);
        chk("fw_dir", 32'(dir), 0);

        // Reverse with wrap: pos=1, then 10,11,01.
        load = 1'b1; load_val = 8'h01;
        tick(1);
        load = 1'b0;
        drive_hold(1'b1, 1'b0, 6, steps);
        chk("rv_10_pos", 32'(pos), 32'h00);
        chk("rv_10_dir", 32'(dir), 1);
        drive_hold(1'b1, 1'b1, 6, steps);
        chk("rv_11_pos", 32'(pos), 32'hFF);
        drive_hold(1'b0, 1'b1, 6, steps);
        chk("rv_01_pos", 32'(pos), 32'hFE);
        chk("rv_01_steps", 32'(steps), 1);
        drive_hold(1'b0, 1'b0, 6, steps);
        chk("rv_00_pos", 32'(pos), 32'hFD);

        // Glitch rejection: b high for only 2 cycles.
        a_in = 1'b0; b_in = 1'b1;
        tick(2);
        drive_hold(1'b0, 1'b0, 6, steps);
        chk("gl_steps", 32'(steps), 0);
        chk("gl_pos", 32'(pos), 32'hFD);
        chk("gl_err", 32'(err), 0);
        drive_hold(1'b0, 1'b1, 6, steps);
        chk("gl_hold_steps", 32'(steps), 1);
        chk("gl_hold_pos", 32'(pos), 32'hFE);
        chk("gl_hold_dir", 32'(dir), 0);
        drive_hold(1'b0, 1'b0, 6, steps);
        chk("gl_back_pos", 32'(pos), 32'hFD);

        // Illegal 00 -> 11.
        drive_hold(1'b1, 1'b1, 6, steps);
        chk("il_err", 32'(err), 1);
        chk("il_pos", 32'(pos), 32'hFD);
        chk("il_steps", 32'(steps), 0);
        chk("il_dir", 32'(dir), 1);
        // clr_err coincident with a further illegal 11 -> 00: set wins.
        a_in = 1'b0; b_in = 1'b0;
        tick(4);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("il_setwins", 32'(err), 1);
        tick(4);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("il_clr", 32'(err), 0);
        chk("il_clr_pos", 32'(pos), 32'hFD);

        // Load on the acceptance edge of an up step (00 -> 01).
        a_in = 1'b0; b_in = 1'b1;
        tick(4);
        load = 1'b1; load_val = 8'h5A;
        tick(1);
        load = 1'b0;
        chk("ld_pos", 32'(pos), 32'h5A);
        chk("ld_step", 32'(step), 0);
        chk("ld_dir", 32'(dir), 1);
        drive_hold(1'b0, 1'b1, 4, steps);
        chk("ld_norecount", 32'(steps), 0);
        chk("ld_hold_pos", 32'(pos), 32'h5A);
        drive_hold(1'b1, 1'b1, 6, steps);
        chk("ld_next_pos", 32'(pos), 32'h5B);
        chk("ld_next_dir", 32'(dir), 0);

        // Reset while a change (11 -> 10) is mid-filter.
        a_in = 1'b1; b_in = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("mr_pos", 32'(pos), 32'h00);
        chk("mr_dir", 32'(dir), 0);
        chk("mr_step", 32'(step), 0);
        chk("mr_err", 32'(err), 0);
        tick(1);
        reset = 1'b0;
        drive_hold(1'b1, 1'b0, 10, steps);
        chk("mr_nocount", 32'(steps), 0);
        chk("mr_hold_pos", 32'(pos), 32'h00);
        drive_hold(1'b0, 1'b0, 6, steps);
        chk("mr_after_pos", 32'(pos), 32'h01);
        chk("mr_after_steps", 32'(steps), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
